// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//   Resolves one conditional branch at a time in the EX stage of the rv32i
//   pipeline. The branch is compared with the fetch-stage prediction. On a
//   mispredict the controller flushes the younger instructions, redirects
//   fetch and then waits for fetch to accept the redirect. Correctly
//   predicted branches are accepted back-to-back, one per cycle.
//   Saturating counters record resolved branches and mispredictions.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   in_valid_i/in_ready_o branch handshake from EX
//   in_op_i               branch funct3
//   in_rs1_i, in_rs2_i    forwarded operands
//   in_pc_i, in_imm_i     branch PC, sign-extended B-immediate
//   in_pred_taken_i       fetch prediction: taken
//   in_pred_target_i      fetch prediction: target
//   flush_o               1-cycle pulse that kills IF/ID
//   redirect_valid_o/redirect_ready_i/redirect_pc_o  redirect to fetch
//   upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o predictor update pulse
//   misalign_o            1-cycle pulse: taken target not word aligned
//   illegal_op_o          1-cycle pulse: funct3 is not a branch
//   br_count_o, mispredict_count_o  saturating statistics
// ---------------------------------------------------------------------------

// Branch comparator: decodes funct3 and evaluates the branch condition.
module cmp_module (
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        taken_o,
    output logic        illegal_o
);

    // funct3 2 and 3 are not branches; they report illegal and never take.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            3'b000:  taken_o = (a_i == b_i);
            3'b001:  taken_o = (a_i != b_i);
            3'b100:  taken_o = ($signed(a_i) <  $signed(b_i));
            3'b101:  taken_o = ($signed(a_i) >= $signed(b_i));
            3'b110:  taken_o = (a_i <  b_i);
            3'b111:  taken_o = (a_i >= b_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

module branch_resolve_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       in_op_i,
    input  logic [31:0]      in_rs1_i,
    input  logic [31:0]      in_rs2_i,
    input  logic [31:0]      in_pc_i,
    input  logic [31:0]      in_imm_i,
    input  logic             in_pred_taken_i,
    input  logic [31:0]      in_pred_target_i,
    output logic             flush_o,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [31:0]      redirect_pc_o,
    output logic             upd_valid_o,
    output logic [31:0]      upd_pc_o,
    output logic [31:0]      upd_target_o,
    output logic             upd_taken_o,
    output logic             misalign_o,
    output logic             illegal_op_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mispredict_count_o
);

    // RESOLVE is the first cycle after a mispredicted branch is accepted.
    typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT} state_t;

    state_t state_q, state_d;

    logic             cmp_taken, cmp_illegal;
    logic             accept, misaligned, mispredict;
    logic [31:0]      target, fallthrough;
    logic             upd_valid_q, upd_taken_q, misalign_q, illegal_q;
    logic [31:0]      upd_pc_q, upd_target_q, redirect_pc_q;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mis_count_q, mis_count_d;

    cmp_module u_cmp (
        .op_i      (in_op_i),
        .a_i       (in_rs1_i),
        .b_i       (in_rs2_i),
        .taken_o   (cmp_taken),
        .illegal_o (cmp_illegal)
    );

    // Accept depends on the state register directly, so there is no loop
    // through the in_ready_o output.
    assign accept      = in_valid_i && (state_q == IDLE);
    assign target      = in_pc_i + in_imm_i;
    assign fallthrough = in_pc_i + 32'd4;
    assign misaligned  = cmp_taken && (target[1:0] != 2'b00);

    // A misaligned taken branch goes to the trap unit. It does not count as
    // a mispredict, so it triggers no flush and no redirect. An illegal op
    // is never taken, so it mispredicts only when fetch predicted taken.
    assign mispredict  = !misaligned &&
                         ((cmp_taken != in_pred_taken_i) ||
                          (cmp_taken && (target != in_pred_target_i)));

    // The state register is the only FSM storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The next state and the handshake outputs are decoded from the state.
    always_comb begin
        state_d          = state_q;
        in_ready_o       = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (accept && mispredict) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                state_d          = redirect_ready_i ? IDLE : REDIRECT;
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Illegal ops leave both counters untouched. Both counters stop at all-ones.
    always_comb begin
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (accept && !cmp_illegal) begin
            if (br_count_q != '1) begin
                br_count_d = br_count_q + CNT_W'(1);
            end
            if (mispredict && (mis_count_q != '1)) begin
                mis_count_d = mis_count_q + CNT_W'(1);
            end
        end
    end

    // The registered result of each accepted branch drives its N+1 pulses.
    // redirect_pc is loaded only on a mispredict, so it holds steady until
    // the redirect handshake completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            misalign_q    <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_pc_q <= '0;
            br_count_q    <= '0;
            mis_count_q   <= '0;
        end else begin
            upd_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
            if (accept) begin
                illegal_q <= cmp_illegal;
                if (!cmp_illegal) begin
                    upd_valid_q  <= 1'b1;
                    upd_taken_q  <= cmp_taken;
                    upd_pc_q     <= in_pc_i;
                    upd_target_q <= target;
                    misalign_q   <= misaligned;
                end
                if (mispredict) begin
                    redirect_pc_q <= cmp_taken ? target : fallthrough;
                end
            end
        end
    end

    assign upd_valid_o        = upd_valid_q;
    assign upd_taken_o        = upd_taken_q;
    assign upd_pc_o           = upd_pc_q;
    assign upd_target_o       = upd_target_q;
    assign misalign_o         = misalign_q;
    assign illegal_op_o       = illegal_q;
    assign redirect_pc_o      = redirect_pc_q;
    assign br_count_o         = br_count_q;
    assign mispredict_count_o = mis_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Table-driven bench for branch_resolve_ctrl. Expected results are queued
//   when a branch is driven and popped when its N+1 outputs are sampled.
//   A second instance with 2-bit counters shares all inputs so that
//   counter saturation can be observed.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        predTaken;
        logic [31:0] predTarget;
        logic        expUpdValid;
        logic        expTaken;
        logic [31:0] expTarget;
        logic        expFlush;
        logic [31:0] expRedirectPc;
        logic        expMisalign;
        logic        expIllegal;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  in_op_i;
    logic [31:0] in_rs1_i, in_rs2_i, in_pc_i, in_imm_i, in_pred_target_i;
    logic        in_pred_taken_i;
    logic        flush_o, redirect_valid_o, redirect_ready_i;
    logic [31:0] redirect_pc_o, upd_pc_o, upd_target_o;
    logic        upd_valid_o, upd_taken_o, misalign_o, illegal_op_o;
    logic [31:0] br_count_o, mispredict_count_o;

    logic        smReady, smFlush, smRedirValid, smUpdValid, smUpdTaken;
    logic        smMisalign, smIllegal;
    logic [31:0] smRedirPc, smUpdPc, smUpdTarget;
    logic [1:0]  smBrCount, smMisCount;

    vec_t        vecs[13];
    vec_t        expQ[$];
    logic [31:0] expBr, expMis;
    logic [1:0]  expSmallBr, expSmallMis;
    int          testsRun = 0;
    int          failCount = 0;

    always #5 clk_i = ~clk_i;

    branch_resolve_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_op_i(in_op_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .in_pc_i(in_pc_i), .in_imm_i(in_imm_i),
        .in_pred_taken_i(in_pred_taken_i), .in_pred_target_i(in_pred_target_i),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
        .redirect_ready_i(redirect_ready_i), .redirect_pc_o(redirect_pc_o),
        .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
        .upd_target_o(upd_target_o), .upd_taken_o(upd_taken_o),
        .misalign_o(misalign_o), .illegal_op_o(illegal_op_o),
        .br_count_o(br_count_o), .mispredict_count_o(mispredict_count_o)
    );

    branch_resolve_ctrl #(.CNT_W(2)) dutSmall (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(smReady),
        .in_op_i(in_op_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .in_pc_i(in_pc_i), .in_imm_i(in_imm_i),
        .in_pred_taken_i(in_pred_taken_i), .in_pred_target_i(in_pred_target_i),
        .flush_o(smFlush), .redirect_valid_o(smRedirValid),
        .redirect_ready_i(redirect_ready_i), .redirect_pc_o(smRedirPc),
        .upd_valid_o(smUpdValid), .upd_pc_o(smUpdPc),
        .upd_target_o(smUpdTarget), .upd_taken_o(smUpdTaken),
        .misalign_o(smMisalign), .illegal_op_o(smIllegal),
        .br_count_o(smBrCount), .mispredict_count_o(smMisCount)
    );

    // A watchdog guarantees that the run ends even if the flow stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(
        input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
        input logic [31:0] pc, input logic [31:0] imm, input logic pt,
        input logic [31:0] ptgt, input logic eUpd, input logic eTaken,
        input logic [31:0] eTgt, input logic eFlush, input logic [31:0] eRpc,
        input logic eMis, input logic eIll);
        vec_t v;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm;
        v.predTaken = pt; v.predTarget = ptgt;
        v.expUpdValid = eUpd; v.expTaken = eTaken; v.expTarget = eTgt;
        v.expFlush = eFlush; v.expRedirectPc = eRpc;
        v.expMisalign = eMis; v.expIllegal = eIll;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one branch for one accepting edge and queues what it should produce.
    task automatic applyStimulus(input vec_t v);
        in_valid_i       = 1'b1;
        in_op_i          = v.op;
        in_rs1_i         = v.rs1;
        in_rs2_i         = v.rs2;
        in_pc_i          = v.pc;
        in_imm_i         = v.imm;
        in_pred_taken_i  = v.predTaken;
        in_pred_target_i = v.predTarget;
        expQ.push_back(v);
        if (!v.expIllegal) begin
            expBr = expBr + 32'd1;
            if (expSmallBr != 2'b11) expSmallBr = expSmallBr + 2'd1;
            if (v.expFlush) begin
                expMis = expMis + 32'd1;
                if (expSmallMis != 2'b11) expSmallMis = expSmallMis + 2'd1;
            end
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    // Samples the N+1 cycle mid-period and compares it against the oldest queued entry.
    task automatic checkOutput();
        vec_t v;
        @(negedge clk_i);
        if (expQ.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL scoreboard: no expected entry queued");
            return;
        end
        v = expQ.pop_front();
        checkVal("upd_valid", upd_valid_o, v.expUpdValid);
        if (v.expUpdValid) begin
            checkVal("upd_taken", upd_taken_o, v.expTaken);
            checkVal("upd_target", upd_target_o, v.expTarget);
            checkVal("upd_pc", upd_pc_o, v.pc);
        end
        checkVal("flush", flush_o, v.expFlush);
        checkVal("redirect_valid", redirect_valid_o, v.expFlush);
        if (v.expFlush) checkVal("redirect_pc", redirect_pc_o, v.expRedirectPc);
        checkVal("misalign", misalign_o, v.expMisalign);
        checkVal("illegal_op", illegal_op_o, v.expIllegal);
        checkVal("in_ready", in_ready_o, !v.expFlush);
        checkVal("br_count", br_count_o, expBr);
        checkVal("mispredict_count", mispredict_count_o, expMis);
        checkVal("small_br_count", smBrCount, expSmallBr);
        checkVal("small_mispredict_count", smMisCount, expSmallMis);
    endtask

    // Runs one branch with fetch always ready and confirms the redirect retires.
    task automatic runVector(input vec_t v);
        applyStimulus(v);
        checkOutput();
        if (v.expFlush) begin
            @(negedge clk_i);
            checkVal("redirect_done_valid", redirect_valid_o, 32'd0);
            checkVal("redirect_done_ready", in_ready_o, 32'd1);
        end
    endtask

    initial begin
        vec_t t3;
        vecs[0]  = mkVec(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120,
                         1'b1, 1'b1, 32'h120, 1'b0, 32'h0, 1'b0, 1'b0);
        vecs[1]  = mkVec(3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'h240, 1'b1, 32'h240, 1'b0, 1'b0);
        vecs[2]  = mkVec(3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h0,
                         1'b1, 1'b0, 32'h240, 1'b0, 32'h0, 1'b0, 1'b0);
        vecs[3]  = mkVec(3'b101, 32'd3, 32'hFFFFFFFE, 32'h400, 32'h10, 1'b1, 32'h410,
                         1'b1, 1'b1, 32'h410, 1'b0, 32'h0, 1'b0, 1'b0);
        vecs[4]  = mkVec(3'b111, 32'hFFFFFFFE, 32'd3, 32'h500, 32'hFFFFFFF0, 1'b1, 32'h4F8,
                         1'b1, 1'b1, 32'h4F0, 1'b1, 32'h4F0, 1'b0, 1'b0);
        vecs[5]  = mkVec(3'b001, 32'd1, 32'd2, 32'h600, 32'h8, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'h608, 1'b1, 32'h608, 1'b0, 1'b0);
        vecs[6]  = mkVec(3'b000, 32'd1, 32'd2, 32'h700, 32'h40, 1'b1, 32'h740,
                         1'b1, 1'b0, 32'h740, 1'b1, 32'h704, 1'b0, 1'b0);
        vecs[7]  = mkVec(3'b111, 32'd0, 32'd0, 32'hFFFFFFFC, 32'h8, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'h4, 1'b1, 32'h4, 1'b0, 1'b0);
        vecs[8]  = mkVec(3'b010, 32'd9, 32'd9, 32'h800, 32'h20, 1'b0, 32'h0,
                         1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vecs[9]  = mkVec(3'b100, 32'd5, 32'd3, 32'h900, 32'h20, 1'b0, 32'h0,
                         1'b1, 1'b0, 32'h920, 1'b0, 32'h0, 1'b0, 1'b0);
        vecs[10] = mkVec(3'b111, 32'd0, 32'd0, 32'hFFFFFFFC, 32'h2, 1'b0, 32'h0,
                         1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b1, 1'b0);
        vecs[11] = mkVec(3'b101, 32'h80000000, 32'h7FFFFFFF, 32'hA00, 32'h10, 1'b1, 32'hA10,
                         1'b1, 1'b0, 32'hA10, 1'b1, 32'hA04, 1'b0, 1'b0);
        vecs[12] = mkVec(3'b110, 32'd0, 32'hFFFFFFFF, 32'hB00, 32'hC, 1'b1, 32'hB0C,
                         1'b1, 1'b1, 32'hB0C, 1'b0, 32'h0, 1'b0, 1'b0);
        t3       = mkVec(3'b001, 32'd1, 32'd1, 32'h300, 32'h80, 1'b1, 32'h380,
                         1'b1, 1'b0, 32'h380, 1'b1, 32'h304, 1'b0, 1'b0);

        rst_i = 1'b1;
        in_valid_i = 1'b0;
        in_op_i = 3'b000;
        in_rs1_i = '0; in_rs2_i = '0; in_pc_i = '0; in_imm_i = '0;
        in_pred_taken_i = 1'b0; in_pred_target_i = '0;
        redirect_ready_i = 1'b1;
        expBr = '0; expMis = '0; expSmallBr = '0; expSmallMis = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkVal("rst_in_ready", in_ready_o, 32'd1);
        checkVal("rst_flush", flush_o, 32'd0);
        checkVal("rst_redirect_valid", redirect_valid_o, 32'd0);
        checkVal("rst_redirect_pc", redirect_pc_o, 32'd0);
        checkVal("rst_upd_valid", upd_valid_o, 32'd0);
        checkVal("rst_upd_pc", upd_pc_o, 32'd0);
        checkVal("rst_upd_target", upd_target_o, 32'd0);
        checkVal("rst_upd_taken", upd_taken_o, 32'd0);
        checkVal("rst_misalign", misalign_o, 32'd0);
        checkVal("rst_illegal_op", illegal_op_o, 32'd0);
        checkVal("rst_br_count", br_count_o, 32'd0);
        checkVal("rst_mispredict_count", mispredict_count_o, 32'd0);
        rst_i = 1'b0;

        // Table vectors, back-to-back whenever no redirect is pending
        for (int i = 0; i < 13; i++) begin
            runVector(vecs[i]);
        end

        // A redirect stalled by fetch for three cycles keeps its PC and blocks new branches
        redirect_ready_i = 1'b0;
        applyStimulus(t3);
        checkOutput();
        in_valid_i = 1'b1;
        in_op_i = 3'b000; in_rs1_i = 32'd7; in_rs2_i = 32'd7;
        in_pc_i = 32'hC00; in_imm_i = 32'h10;
        in_pred_taken_i = 1'b1; in_pred_target_i = 32'hC10;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            checkVal("t3_hold_valid", redirect_valid_o, 32'd1);
            checkVal("t3_hold_pc", redirect_pc_o, 32'h304);
            checkVal("t3_no_flush", flush_o, 32'd0);
            checkVal("t3_ready_low", in_ready_o, 32'd0);
            checkVal("t3_br_held", br_count_o, expBr);
            if (k == 3) begin
                redirect_ready_i = 1'b1;
                in_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        checkVal("t3_done_valid", redirect_valid_o, 32'd0);
        checkVal("t3_done_ready", in_ready_o, 32'd1);
        checkVal("t3_br_final", br_count_o, expBr);
        checkVal("t3_mis_final", mispredict_count_o, expMis);

        // Reset while a redirect is waiting drops it and clears the counters
        redirect_ready_i = 1'b0;
        applyStimulus(vecs[5]);
        checkOutput();
        @(negedge clk_i);
        checkVal("t6_in_redirect", redirect_valid_o, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkVal("t6_redirect_valid", redirect_valid_o, 32'd0);
        checkVal("t6_in_ready", in_ready_o, 32'd1);
        checkVal("t6_br_count", br_count_o, 32'd0);
        checkVal("t6_mispredict_count", mispredict_count_o, 32'd0);
        checkVal("t6_small_br_count", smBrCount, 32'd0);
        rst_i = 1'b0;
        redirect_ready_i = 1'b1;
        expBr = '0; expMis = '0; expSmallBr = '0; expSmallMis = '0;

        // Four correct predictions back-to-back, then mispredicts until the 2-bit counters saturate
        for (int i = 0; i < 4; i++) begin
            runVector(mkVec(3'b000, 32'd5, 32'd5, 32'h1000 + 32'(i * 16), 32'h20, 1'b1,
                            32'h1020 + 32'(i * 16), 1'b1, 1'b1, 32'h1020 + 32'(i * 16),
                            1'b0, 32'h0, 1'b0, 1'b0));
        end
        checkVal("t5_br_count_four", br_count_o, 32'd4);
        for (int i = 0; i < 4; i++) begin
            runVector(mkVec(3'b001, 32'd1, 32'd2, 32'h2000 + 32'(i * 16), 32'h8, 1'b0, 32'h0,
                            1'b1, 1'b1, 32'h2008 + 32'(i * 16), 1'b1, 32'h2008 + 32'(i * 16),
                            1'b0, 1'b0));
        end
        checkVal("sat_small_mis", smMisCount, 32'd3);
        checkVal("sat_small_br", smBrCount, 32'd3);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
